// File: rtl/dbg_bridge_pkg.sv
// Shared definitions for the host-side debug command bridge: FSM encoding,
// framing defaults and LEN-byte flag positions.
package dbg_bridge_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_GOT_SYNC = 3'd1;
    localparam state_t ST_ISSUE    = 3'd2;
    localparam state_t ST_COLLECT  = 3'd3;
    localparam state_t ST_TX_SOF   = 3'd4;
    localparam state_t ST_TX_LEN   = 3'd5;
    localparam state_t ST_TX_DATA  = 3'd6;
    localparam state_t ST_TX_CSUM  = 3'd7;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] RESP_SOF_DEF  = 8'h5A;

    localparam int LEN_OVF_BIT = 7;
    localparam int LEN_TO_BIT  = 6;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dbg_resp_fifo.sv
// Response byte buffer: synchronous FIFO with clear; pushes while full and
// pops while empty are dropped internally.
module dbg_resp_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [3:0] count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [3:0]       cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == 4'(FIFO_DEPTH));
    assign empty_o = (cnt_q == 4'd0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= 4'd0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (do_push && !do_pop)      cnt_q <= cnt_q + 4'd1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 4'd1;
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/debug_cmd_bridge.sv
// Host-side debug front end: deframes A5,cmd from the RX byte stream, strobes
// the command, collects the response burst and returns it as a framed packet.
module debug_cmd_bridge
    import dbg_bridge_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
    parameter logic [7:0] RESP_SOF   = RESP_SOF_DEF,
    parameter int         FIFO_DEPTH = 8,
    parameter int         RESP_GAP   = 4,
    parameter int         TIMEOUT    = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] debug_cmd,
    output logic       debug_cmd_valid,
    input  logic [7:0] debug_resp,
    input  logic       debug_resp_valid,
    output logic       busy,
    output logic [7:0] drop_count,
    output logic [7:0] timeout_count
);

    localparam int GAP_W = $clog2(RESP_GAP + 1);
    localparam int TO_W  = $clog2(TIMEOUT);

    state_t           state_q, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             ovf_q, ovf_d, to_q, to_d;
    logic [7:0]       drop_q, drop_d, tocnt_q, tocnt_d;
    logic [7:0]       csum_q, csum_d;
    logic [7:0]       len_byte, fifo_data;
    logic [3:0]       fifo_count;
    logic             fifo_clear, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic             tx_fire;

    dbg_resp_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (fifo_clear),
        .push_i  (fifo_push),
        .data_i  (debug_resp),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign busy            = (state_q != ST_IDLE) && (state_q != ST_GOT_SYNC);
    assign tx_valid        = state_q[2];
    assign tx_fire         = tx_valid && tx_ready;
    assign debug_cmd_valid = (state_q == ST_ISSUE);
    assign debug_cmd       = cmd_q;
    assign drop_count      = drop_q;
    assign timeout_count   = tocnt_q;

    always_comb begin
        len_byte              = {4'd0, fifo_count};
        len_byte[LEN_OVF_BIT] = ovf_q;
        len_byte[LEN_TO_BIT]  = to_q;
    end

    always_comb begin
        case (state_q)
            ST_TX_SOF:  tx_data = RESP_SOF;
            ST_TX_LEN:  tx_data = len_byte;
            ST_TX_DATA: tx_data = fifo_data;
            ST_TX_CSUM: tx_data = csum_q;
            default:    tx_data = 8'd0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        gap_d      = gap_q;
        to_cnt_d   = to_cnt_q;
        ovf_d      = ovf_q;
        to_d       = to_q;
        drop_d     = drop_q;
        tocnt_d    = tocnt_q;
        csum_d     = csum_q;
        fifo_clear = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        if (rx_valid && busy) drop_d = sat_inc8(drop_q);
        case (state_q)
            ST_IDLE:     if (rx_valid && rx_data == SYNC_BYTE) state_d = ST_GOT_SYNC;
            ST_GOT_SYNC: if (rx_valid) begin
                cmd_d   = rx_data;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                fifo_clear = 1'b1;
                gap_d      = '0;
                to_cnt_d   = '0;
                ovf_d      = 1'b0;
                to_d       = 1'b0;
                state_d    = ST_COLLECT;
            end
            // Gap timing only starts once a byte has arrived; until then the timeout runs.
            ST_COLLECT: begin
                if (debug_resp_valid) begin
                    fifo_push = 1'b1;
                    gap_d     = '0;
                    if (fifo_full) ovf_d = 1'b1;
                end else if (!fifo_empty) begin
                    if (gap_q == GAP_W'(RESP_GAP)) state_d = ST_TX_SOF;
                    else                           gap_d   = gap_q + 1'b1;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    tocnt_d = sat_inc8(tocnt_q);
                    state_d = ST_TX_SOF;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_TX_SOF: if (tx_fire) state_d = ST_TX_LEN;
            ST_TX_LEN: if (tx_fire) begin
                csum_d  = len_byte;
                state_d = fifo_empty ? ST_TX_CSUM : ST_TX_DATA;
            end
            ST_TX_DATA: if (tx_fire) begin
                fifo_pop = 1'b1;
                csum_d   = csum_q ^ fifo_data;
                if (fifo_count == 4'd1) state_d = ST_TX_CSUM;
            end
            ST_TX_CSUM: if (tx_fire) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cmd_q    <= 8'd0;
            gap_q    <= '0;
            to_cnt_q <= '0;
            ovf_q    <= 1'b0;
            to_q     <= 1'b0;
            drop_q   <= 8'd0;
            tocnt_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            gap_q    <= gap_d;
            to_cnt_q <= to_cnt_d;
            ovf_q    <= ovf_d;
            to_q     <= to_d;
            drop_q   <= drop_d;
            tocnt_q  <= tocnt_d;
        end
    end

    always_ff @(posedge clk) begin
        csum_q <= csum_d;
    end

endmodule

// File: tb/tb_debug_cmd_bridge.sv
// Scoreboard bench for debug_cmd_bridge: directed frames push expected TX bytes
// and command strobes; a negedge monitor pops and compares.
module tb_debug_cmd_bridge;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] debug_cmd;
    logic       debug_cmd_valid;
    logic [7:0] debug_resp;
    logic       debug_resp_valid;
    logic       busy;
    logic [7:0] drop_count;
    logic [7:0] timeout_count;

    debug_cmd_bridge #(
        .SYNC_BYTE (8'hA5),
        .RESP_SOF  (8'h5A),
        .FIFO_DEPTH(8),
        .RESP_GAP  (4),
        .TIMEOUT   (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .debug_cmd       (debug_cmd),
        .debug_cmd_valid (debug_cmd_valid),
        .debug_resp      (debug_resp),
        .debug_resp_valid(debug_resp_valid),
        .busy            (busy),
        .drop_count      (drop_count),
        .timeout_count   (timeout_count)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    logic [7:0] cmd_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] data_prev = 8'd0;
    logic       cmd_prev = 1'b0;
    logic [7:0] mon_exp;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Monitor: compares every transferred TX byte and every command strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                stall_prev = 1'b0;
                cmd_prev   = 1'b0;
            end else begin
                if (stall_prev) begin
                    check8("hold_valid", {7'd0, tx_valid}, 8'd1);
                    check8("hold_data", tx_data, data_prev);
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_extra: got %02h expected no byte", tx_data);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check8("tx_byte", tx_data, mon_exp);
                    end
                end
                stall_prev = tx_valid && !tx_ready;
                data_prev  = tx_data;
                if (debug_cmd_valid) begin
                    if (cmd_prev || cmd_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL cmd_pulse: got strobe cmd=%02h expected none", debug_cmd);
                    end else begin
                        mon_exp = cmd_q.pop_front();
                        check8("debug_cmd", debug_cmd, mon_exp);
                    end
                end
                cmd_prev = debug_cmd_valid;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
    endtask

    task automatic resp(input logic [7:0] b);
        debug_resp       = b;
        debug_resp_valid = 1'b1;
        step(1);
        debug_resp_valid = 1'b0;
    endtask

    task automatic expect_bytes(input logic [7:0] b[$]);
        foreach (b[i]) exp_q.push_back(b[i]);
    endtask

    task automatic wait_pending(input string name, input int level);
        int n = 0;
        while (exp_q.size() > level && n < 200) begin
            step(1);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_wait: got %0d bytes pending expected %0d", name, exp_q.size(), level);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            step(1);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_done: got %0d bytes pending busy=%0d expected 0", name, exp_q.size(), busy);
            exp_q.delete();
        end
        check8({name, "_cmd_left"}, 8'(cmd_q.size()), 8'd0);
    endtask

    initial begin
        rst_n            = 1'b0;
        rx_data          = 8'd0;
        rx_valid         = 1'b0;
        tx_ready         = 1'b1;
        debug_resp       = 8'd0;
        debug_resp_valid = 1'b0;
        step(3);
        check8("rst_tx_valid", {7'd0, tx_valid}, 8'd0);
        check8("rst_tx_data", tx_data, 8'd0);
        check8("rst_busy", {7'd0, busy}, 8'd0);
        check8("rst_cmd", debug_cmd, 8'd0);
        check8("rst_cmd_valid", {7'd0, debug_cmd_valid}, 8'd0);
        check8("rst_drop", drop_count, 8'd0);
        check8("rst_timeout", timeout_count, 8'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step(1);

        // Status round trip, including first-TX-byte latency.
        cmd_q.push_back(8'h01);
        expect_bytes('{8'h5A, 8'h04, 8'h01, 8'h0E, 8'h05, 8'h00, 8'h0E});
        rx(8'hA5);
        rx(8'h01);
        step(1);
        resp(8'h01);
        resp(8'h0E);
        resp(8'h05);
        resp(8'h00);
        step(4);
        check8("lat_not_yet", {7'd0, tx_valid}, 8'd0);
        step(1);
        check8("lat_first", {7'd0, tx_valid}, 8'd1);
        wait_done("status");
        check8("cmd_hold", debug_cmd, 8'h01);

        // Timeout with no response.
        cmd_q.push_back(8'hF0);
        expect_bytes('{8'h5A, 8'h40, 8'h40});
        rx(8'hA5);
        rx(8'hF0);
        wait_done("timeout");
        check8("timeout_count", timeout_count, 8'd1);

        // Overflow: 10 bytes into an 8-deep buffer.
        cmd_q.push_back(8'h03);
        expect_bytes('{8'h5A, 8'h88, 8'h00, 8'h01, 8'h02, 8'h03,
                       8'h04, 8'h05, 8'h06, 8'h07, 8'h88});
        rx(8'hA5);
        rx(8'h03);
        step(1);
        for (int i = 0; i < 10; i++) resp(8'(i));
        wait_done("overflow");

        // Backpressure in the middle of the data bytes.
        cmd_q.push_back(8'h02);
        expect_bytes('{8'h5A, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
        rx(8'hA5);
        rx(8'h02);
        step(1);
        resp(8'h11);
        resp(8'h22);
        resp(8'h33);
        wait_pending("bp", 3);
        tx_ready = 1'b0;
        step(5);
        tx_ready = 1'b1;
        wait_done("backpressure");

        // Noise in IDLE ignored, bytes during COLLECT dropped and counted.
        rx(8'h33);
        step(2);
        check8("idle_noise_drop", drop_count, 8'd0);
        cmd_q.push_back(8'h04);
        expect_bytes('{8'h5A, 8'h02, 8'h0A, 8'h0B, 8'h03});
        rx(8'hA5);
        rx(8'h04);
        step(1);
        resp(8'h0A);
        resp(8'h0B);
        rx(8'h11);
        rx(8'h22);
        rx(8'h33);
        wait_done("noise");
        check8("drop_count", drop_count, 8'd3);

        // Reset during TX_DATA, then a fresh command.
        cmd_q.push_back(8'h00);
        expect_bytes('{8'h5A, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00});
        rx(8'hA5);
        rx(8'h00);
        step(1);
        resp(8'h01);
        resp(8'h02);
        resp(8'h03);
        resp(8'h04);
        wait_pending("rst", 4);
        mon_en   = 1'b0;
        rst_n    = 1'b0;
        tx_ready = 1'b0;
        exp_q.delete();
        step(1);
        check8("mid_rst_tx_valid", {7'd0, tx_valid}, 8'd0);
        check8("mid_rst_busy", {7'd0, busy}, 8'd0);
        check8("mid_rst_drop", drop_count, 8'd0);
        check8("mid_rst_timeout", timeout_count, 8'd0);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        step(1);
        mon_en = 1'b1;
        cmd_q.push_back(8'h00);
        expect_bytes('{8'h5A, 8'h01, 8'h7E, 8'h7F});
        rx(8'hA5);
        rx(8'h00);
        step(1);
        resp(8'h7E);
        wait_done("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
